softusb_pktrx: RTL and testbench
================================

SOFTUSB_PKTRX -- requirements
Module: softusb_pktrx

Interface
Parameters: name, default, meaning.
- REQ-001: MAX_PAYLOAD, 64, maximum DATA payload bytes, excluding PID and CRC16.

Ports: name, direction, width, meaning.
- REQ-002: usb_clk, in, 1, sole clock; all logic on rising edge.
- REQ-003: usb_rst_n, in, 1, reset; asynchronous, active-low.
- REQ-004: rx_data, in, 8, received byte from softusb_rx, SYNC already stripped.
- REQ-005: rx_valid, in, 1, rx_data valid this cycle (single-cycle strobe).
- REQ-006: rx_active, in, 1, packet in progress; falls at EOP.
- REQ-007: pid, out, 4, PID[3:0] of the last accepted packet.
- REQ-008: tok_done, out, 1, one-cycle pulse when a token packet completes.
- REQ-009: tok_addr, out, 7, token address field; also frame[6:0] for SOF.
- REQ-010: tok_endp, out, 4, token endpoint field; also frame[10:7] for SOF.
- REQ-011: data_byte, out, 8, payload byte.
- REQ-012: data_strobe, out, 1, one-cycle pulse; data_byte valid.
- REQ-013: data_done, out, 1, one-cycle pulse when a DATA0/DATA1 packet ends.
- REQ-014: hs_done, out, 1, one-cycle pulse when an ACK/NAK/STALL packet ends.
- REQ-015: crc_ok, out, 1, CRC result; valid with tok_done/data_done.
- REQ-016: err, out, 1, one-cycle pulse on any malformed packet.

Function
- REQ-017: FSM states SHALL be IDLE, PID, TOK1, TOK2, DATA, HS, WAITEOP, DISCARD.
- REQ-018: IDLE->PID on rx_active=1.
- REQ-019: In PID, the first rx_valid byte SHALL be checked for byte[7:4] == ~byte[3:0].
  - Check fail or unknown PID: ->DISCARD.
  - PID 1/9/D/5 (OUT/IN/SETUP/SOF): ->TOK1.
  - PID 3/B (DATA0/DATA1): ->DATA.
  - PID 2/A/E (ACK/NAK/STALL): ->HS.
- REQ-020: The pid output SHALL update only when the PID check passes.
- REQ-021: Bits SHALL be processed LSB-first for both CRCs.
- REQ-022: CRC5 SHALL use poly x^5+x^2+1, init 5'b11111, run over the 16 token bits, with good residual 5'b01100.
- REQ-023: CRC16 SHALL use poly 0x8005, init 16'hFFFF, run over payload plus CRC bytes, with good residual 16'b1000000000001101.
- REQ-024: TOK1 stores byte1 and goes to TOK2; TOK2 stores byte2 and goes to WAITEOP.
- REQ-025: Token field mapping: tok_addr = byte1[6:0]; tok_endp = {byte2[2:0], byte1[7]}.
- REQ-026: In DATA, a 2-byte delay line SHALL hold the last two bytes.
  - On each new byte while the line is full, the oldest byte is emitted: data_byte set and data_strobe pulsed 1 cycle after the rx_valid cycle.
  - The CRC16 bytes SHALL never be emitted.
- REQ-027: If a DATA packet's payload byte count exceeds MAX_PAYLOAD, the block SHALL pulse err and go to DISCARD; no data_done is issued.
- REQ-028: Any rx_valid in WAITEOP or HS (extra byte) SHALL cause err and ->DISCARD.
- REQ-029: On rx_active falling edge, the block SHALL issue exactly one of the following, in the cycle after the edge, then return to IDLE:
  - in WAITEOP after a token: tok_done with crc_ok = (CRC5 residual good);
  - in DATA with at least 2 bytes received: data_done with crc_ok = (CRC16 residual good);
  - in HS: hs_done;
  - in PID, TOK1, TOK2, or DATA with fewer than 2 bytes: err.
- REQ-030: DISCARD SHALL ignore all bytes and return to IDLE when rx_active falls, with no further pulses.
- REQ-031: If rx_valid and the rx_active fall occur in the same cycle, the byte SHALL be processed first, then end-of-packet is evaluated.
- REQ-032: A new rx_active rise in the cycle a done/err pulse is issued SHALL still be accepted.

Reset
- REQ-033: While usb_rst_n=0, the block SHALL be in state IDLE, all pulses 0, pid/tok_addr/tok_endp/data_byte 0, crc_ok 0, CRCs at init, and the delay line empty.
- REQ-034: Reset asserted mid-packet SHALL abort the packet with no pulses.
- REQ-035: After reset release, bytes SHALL be ignored until the next rx_active rise.

Verification
- REQ-036: Bytes 2D 00 10 -> tok_done=1, pid=D, tok_addr=0, tok_endp=0, crc_ok=1, err never asserted.
- REQ-037: Bytes C3 80 06 00 01 00 00 40 00 DD 94 -> eight data_strobe pulses carrying 80 06 00 01 00 00 40 00, then data_done with crc_ok=1.
- REQ-038: The REQ-037 packet with last byte 95 -> same eight strobes, then data_done with crc_ok=0.
- REQ-039: Bytes D2 -> hs_done=1, pid=2; bytes D3 -> err=1, no hs_done, pid unchanged.
- REQ-040: Bytes 69 00 followed by rx_active falling -> err=1 and no tok_done; a following 69 00 10 -> tok_done, pid=9, crc_ok=1.
- REQ-041: Reset pulse after C3 80 06 -> no data_strobe and no data_done; the next packet decodes normally.

Source files
------------

// File: rtl/softusb_pktrx.sv
// USB packet receiver: classifies packets by PID, extracts token fields, streams DATA
// payload through a 2-byte delay line so the CRC16 bytes are never emitted, and checks CRC5/CRC16.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for rx_active to rise
// PID       | waiting for the PID byte
// TOK1      | token, waiting for byte 1 (addr, endp[0])
// TOK2      | token, waiting for byte 2 (endp[3:1], crc5)
// DATA      | DATA0/DATA1 payload + CRC16 bytes
// HS        | handshake received, expecting EOP only
// WAITEOP   | token complete, expecting EOP only
// DISCARD   | malformed packet, drop everything until EOP
module softusb_pktrx #(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       usb_clk,
  input  logic       usb_rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_active,
  output logic [3:0] pid,
  output logic       tok_done,
  output logic [6:0] tok_addr,
  output logic [3:0] tok_endp,
  output logic [7:0] data_byte,
  output logic       data_strobe,
  output logic       data_done,
  output logic       hs_done,
  output logic       crc_ok,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_TOK1, S_TOK2, S_DATA, S_HS, S_WAITEOP, S_DISCARD
  } state_t;

  localparam int CW = $clog2(MAX_PAYLOAD + 4);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PAYLOAD + 2);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);

  function automatic logic [4:0] crc5_byte(input logic [4:0] c_in, input logic [7:0] d);
    logic [4:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[4] ^ d[i]) c = {c[3:0], 1'b0} ^ 5'b00101;
      else             c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  state_t state_q, state_d, st_b;
  logic act_q;
  logic [3:0] pid_q, pid_d;
  logic [6:0] tok_addr_q, tok_addr_d;
  logic [3:0] tok_endp_q, tok_endp_d;
  logic [7:0] data_byte_q, data_byte_d;
  logic data_strobe_q, data_strobe_d, data_done_q, data_done_d;
  logic tok_done_q, tok_done_d, hs_done_q, hs_done_d;
  logic crc_ok_q, crc_ok_d, err_q, err_d;
  logic [4:0] crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;
  logic [7:0] dl0_q, dl0_d, dl1_q, dl1_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic rise, fall, pid_chk, pid_tok, pid_dat, pid_hs, ovf;

  assign rise    = rx_active & ~act_q;
  assign fall    = act_q & ~rx_active;
  assign pid_chk = (rx_data[7:4] == ~rx_data[3:0]);
  assign pid_tok = (rx_data[3:0] == 4'h1) || (rx_data[3:0] == 4'h9) ||
                   (rx_data[3:0] == 4'hD) || (rx_data[3:0] == 4'h5);
  assign pid_dat = (rx_data[3:0] == 4'h3) || (rx_data[3:0] == 4'hB);
  assign pid_hs  = (rx_data[3:0] == 4'h2) || (rx_data[3:0] == 4'hA) ||
                   (rx_data[3:0] == 4'hE);
  assign ovf     = (cnt_q == CNT_LAST);

  always_ff @(posedge usb_clk or negedge usb_rst_n) begin
    if (!usb_rst_n) begin
      state_q <= S_IDLE;
      act_q   <= 1'b1; // a packet already in flight at reset release is not a rise
    end else begin
      state_q <= state_d;
      act_q   <= rx_active;
    end
  end

  // st_b is the state after consuming this cycle's byte; EOP is then judged from it
  always_comb begin
    st_b = state_q;
    case (state_q)
      S_PID: if (rx_valid) begin
        if (!pid_chk)     st_b = S_DISCARD;
        else if (pid_tok) st_b = S_TOK1;
        else if (pid_dat) st_b = S_DATA;
        else if (pid_hs)  st_b = S_HS;
        else              st_b = S_DISCARD;
      end
      S_TOK1:            if (rx_valid) st_b = S_TOK2;
      S_TOK2:            if (rx_valid) st_b = S_WAITEOP;
      S_DATA:            if (rx_valid && ovf) st_b = S_DISCARD;
      S_HS, S_WAITEOP:   if (rx_valid) st_b = S_DISCARD;
      default: ;
    endcase
    state_d = st_b;
    if (state_q == S_IDLE) state_d = rise ? S_PID : S_IDLE;
    else if (fall)         state_d = S_IDLE;
  end

  always_comb begin
    pid_d         = pid_q;
    tok_addr_d    = tok_addr_q;
    tok_endp_d    = tok_endp_q;
    data_byte_d   = data_byte_q;
    crc_ok_d      = crc_ok_q;
    crc5_d        = crc5_q;
    crc16_d       = crc16_q;
    dl0_d         = dl0_q;
    dl1_d         = dl1_q;
    cnt_d         = cnt_q;
    data_strobe_d = 1'b0;
    data_done_d   = 1'b0;
    tok_done_d    = 1'b0;
    hs_done_d     = 1'b0;

    if (state_q == S_IDLE && rise) begin
      crc5_d  = 5'h1F;
      crc16_d = 16'hFFFF;
      cnt_d   = '0;
    end

    if (rx_valid) begin
      case (state_q)
        S_PID: if (pid_chk) pid_d = rx_data[3:0];
        S_TOK1: begin
          tok_addr_d = rx_data[6:0];
          tok_endp_d = {tok_endp_q[3:1], rx_data[7]};
          crc5_d     = crc5_byte(crc5_q, rx_data);
        end
        S_TOK2: begin
          tok_endp_d = {rx_data[2:0], tok_endp_q[0]};
          crc5_d     = crc5_byte(crc5_q, rx_data);
        end
        S_DATA: if (!ovf) begin
          crc16_d = crc16_byte(crc16_q, rx_data);
          cnt_d   = cnt_q + CW'(1);
          dl0_d   = rx_data;
          dl1_d   = dl0_q;
          if (cnt_q >= CNT_TWO) begin
            data_byte_d   = dl1_q;
            data_strobe_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    err_d = (st_b == S_DISCARD) && (state_q != S_DISCARD);

    if (fall && state_q != S_IDLE) begin
      case (st_b)
        S_WAITEOP: begin
          tok_done_d = 1'b1;
          crc_ok_d   = (crc5_d == 5'b01100);
        end
        S_DATA: begin
          if (cnt_d >= CNT_TWO) begin
            data_done_d = 1'b1;
            crc_ok_d    = (crc16_d == 16'h800D);
          end else begin
            err_d = 1'b1;
          end
        end
        S_HS:                 hs_done_d = 1'b1;
        S_PID, S_TOK1, S_TOK2: err_d    = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge usb_clk or negedge usb_rst_n) begin
    if (!usb_rst_n) begin
      pid_q         <= '0;
      tok_addr_q    <= '0;
      tok_endp_q    <= '0;
      data_byte_q   <= '0;
      data_strobe_q <= 1'b0;
      data_done_q   <= 1'b0;
      tok_done_q    <= 1'b0;
      hs_done_q     <= 1'b0;
      crc_ok_q      <= 1'b0;
      err_q         <= 1'b0;
      crc5_q        <= 5'h1F;
      crc16_q       <= 16'hFFFF;
      dl0_q         <= '0;
      dl1_q         <= '0;
      cnt_q         <= '0;
    end else begin
      pid_q         <= pid_d;
      tok_addr_q    <= tok_addr_d;
      tok_endp_q    <= tok_endp_d;
      data_byte_q   <= data_byte_d;
      data_strobe_q <= data_strobe_d;
      data_done_q   <= data_done_d;
      tok_done_q    <= tok_done_d;
      hs_done_q     <= hs_done_d;
      crc_ok_q      <= crc_ok_d;
      err_q         <= err_d;
      crc5_q        <= crc5_d;
      crc16_q       <= crc16_d;
      dl0_q         <= dl0_d;
      dl1_q         <= dl1_d;
      cnt_q         <= cnt_d;
    end
  end

  assign pid         = pid_q;
  assign tok_done    = tok_done_q;
  assign tok_addr    = tok_addr_q;
  assign tok_endp    = tok_endp_q;
  assign data_byte   = data_byte_q;
  assign data_strobe = data_strobe_q;
  assign data_done   = data_done_q;
  assign hs_done     = hs_done_q;
  assign crc_ok      = crc_ok_q;
  assign err         = err_q;

endmodule

// File: tb/tb_softusb_pktrx.sv
// Directed bench for softusb_pktrx: token, data, handshake, malformed, overflow and reset cases.
module tb_softusb_pktrx;
  localparam int MAXP = 64;

  logic       usb_clk = 1'b0;
  logic       usb_rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_active = 1'b0;
  logic [3:0] pid;
  logic       tok_done;
  logic [6:0] tok_addr;
  logic [3:0] tok_endp;
  logic [7:0] data_byte;
  logic       data_strobe;
  logic       data_done;
  logic       hs_done;
  logic       crc_ok;
  logic       err;

  softusb_pktrx #(.MAX_PAYLOAD(MAXP)) dut (
    .usb_clk(usb_clk), .usb_rst_n(usb_rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_active(rx_active), .pid(pid), .tok_done(tok_done), .tok_addr(tok_addr),
    .tok_endp(tok_endp), .data_byte(data_byte), .data_strobe(data_strobe),
    .data_done(data_done), .hs_done(hs_done), .crc_ok(crc_ok), .err(err)
  );

  always #5 usb_clk = ~usb_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_tok, n_str, n_dd, n_hs, n_err;
  logic crc_at;
  logic [7:0] got_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_pl[8] = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};

  always @(negedge usb_clk) begin
    if (tok_done) n_tok++;
    if (data_done) n_dd++;
    if (hs_done) n_hs++;
    if (err) n_err++;
    if (data_strobe) begin n_str++; got_q.push_back(data_byte); end
    if (tok_done || data_done) crc_at = crc_ok;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_tok = 0; n_str = 0; n_dd = 0; n_hs = 0; n_err = 0;
    crc_at = 1'bx;
    got_q.delete();
  endtask

  // Entered on a falling edge; bytes go out one every two cycles.
  task automatic send(input bit fall_last, input bit tail);
    rx_active = 1'b1;
    @(negedge usb_clk);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i > 0) @(negedge usb_clk);
      rx_valid = 1'b1;
      rx_data  = tx_q[i];
      if (fall_last && i == tx_q.size() - 1) rx_active = 1'b0;
      @(negedge usb_clk);
      rx_valid = 1'b0;
    end
    if (!fall_last) begin
      @(negedge usb_clk);
      rx_active = 1'b0;
    end
    if (tail) repeat (4) @(negedge usb_clk);
  endtask

  task automatic chk_payload(input string tag);
    chk({tag, "_nstr"}, n_str, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_b%0d", tag, i), (got_q.size() > i) ? {24'h0, got_q[i]} : 32'hFFFF, {24'h0, exp_pl[i]});
  endtask

  initial begin
    clr();
    repeat (3) @(negedge usb_clk);
    chk("rst_pid", pid, 0);
    chk("rst_addr", tok_addr, 0);
    chk("rst_endp", tok_endp, 0);
    chk("rst_dbyte", data_byte, 0);
    chk("rst_flags", {tok_done, data_strobe, data_done, hs_done, crc_ok, err}, 0);
    usb_rst_n = 1'b1;
    repeat (2) @(negedge usb_clk);

    clr(); tx_q = '{8'h2D, 8'h00, 8'h10}; send(0, 1);
    chk("setup_tok", n_tok, 1);
    chk("setup_pid", pid, 4'hD);
    chk("setup_addr", tok_addr, 0);
    chk("setup_endp", tok_endp, 0);
    chk("setup_crc", crc_at, 1);
    chk("setup_err", n_err, 0);

    clr(); tx_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    send(0, 1);
    chk_payload("dgood");
    chk("dgood_done", n_dd, 1);
    chk("dgood_crc", crc_at, 1);
    chk("dgood_err", n_err, 0);

    clr(); tx_q[10] = 8'h95; send(0, 1);
    chk_payload("dbad");
    chk("dbad_done", n_dd, 1);
    chk("dbad_crc", crc_at, 0);

    clr(); tx_q = '{8'hD2}; send(0, 1);
    chk("ack_hs", n_hs, 1);
    chk("ack_pid", pid, 4'h2);
    clr(); tx_q = '{8'hD3}; send(0, 1);
    chk("badpid_err", n_err, 1);
    chk("badpid_hs", n_hs, 0);
    chk("badpid_pid", pid, 4'h2);

    clr(); tx_q = '{8'h69, 8'h00}; send(0, 1);
    chk("short_err", n_err, 1);
    chk("short_tok", n_tok, 0);
    clr(); tx_q = '{8'h69, 8'h00, 8'h10}; send(0, 1);
    chk("in_tok", n_tok, 1);
    chk("in_pid", pid, 4'h9);
    chk("in_crc", crc_at, 1);

    // byte and EOP in the same cycle, next packet rising during the done pulse
    clr(); tx_q = '{8'hE1, 8'h95, 8'h0B}; send(1, 0);
    tx_q = '{8'hD2}; send(0, 1);
    chk("b2b_tok", n_tok, 1);
    chk("b2b_addr", tok_addr, 7'h15);
    chk("b2b_endp", tok_endp, 4'h7);
    chk("b2b_crc", crc_at, 0);
    chk("b2b_hs", n_hs, 1);
    chk("b2b_pid", pid, 4'h2);
    chk("b2b_err", n_err, 0);

    clr(); tx_q = '{8'h2D, 8'h00, 8'h10, 8'hAA}; send(0, 1);
    chk("xtra_err", n_err, 1);
    chk("xtra_tok", n_tok, 0);
    clr(); tx_q = '{8'hC3, 8'h11}; send(0, 1);
    chk("d1_err", n_err, 1);
    chk("d1_done", n_dd, 0);

    clr(); tx_q = '{8'h4B};
    for (int i = 0; i < MAXP + 2; i++) tx_q.push_back(8'(i));
    send(0, 1);
    chk("max_done", n_dd, 1);
    chk("max_nstr", n_str, MAXP);
    chk("max_err", n_err, 0);
    chk("max_last", (got_q.size() == MAXP) ? {24'h0, got_q[MAXP-1]} : 32'hFFFF, MAXP - 1);
    clr(); tx_q.push_back(8'hEE); send(0, 1);
    chk("ovf_err", n_err, 1);
    chk("ovf_done", n_dd, 0);
    chk("ovf_nstr", n_str, MAXP);

    clr();
    rx_active = 1'b1;
    @(negedge usb_clk);
    tx_q = '{8'hC3, 8'h80, 8'h06};
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_data = tx_q[i];
      @(negedge usb_clk); rx_valid = 1'b0;
      @(negedge usb_clk);
    end
    usb_rst_n = 1'b0;
    repeat (2) @(negedge usb_clk);
    usb_rst_n = 1'b1;
    @(negedge usb_clk);
    rx_valid = 1'b1; rx_data = 8'hD2;
    @(negedge usb_clk); rx_valid = 1'b0;
    @(negedge usb_clk); rx_active = 1'b0;
    repeat (4) @(negedge usb_clk);
    chk("mrst_nstr", n_str, 0);
    chk("mrst_dd", n_dd, 0);
    chk("mrst_quiet", n_err + n_hs + n_tok, 0);
    clr(); tx_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    send(0, 1);
    chk_payload("post");
    chk("post_done", n_dd, 1);
    chk("post_crc", crc_at, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
